sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Multi-cycle controller for the data memory used by the MEM stage of the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Converts a single-cycle 32-bit load/store request into two sequenced 16-bit accesses on an external asynchronous SRAM.
- Drives `ready`. Top level derives the pipeline-wide `freeze` as (`rd_en` | `wr_en`) & ~`ready` and routes it to the IF stage, the IF/ID register and the hazard path.

Parameters:
- WAIT_CYCLES, 3, clock cycles spent on each 16-bit half access; legal range ≥ 2.
- DATA_MEM_BASE, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from MEM stage; held stable while frozen.
- wr_en  in  1  store request from MEM stage; held stable while frozen.
- address  in  32  byte address (ALU result); word aligned, at or above DATA_MEM_BASE.
- write_data  in  32  store data.
- read_data  out  32  registered load result.
- ready  out  1  high when no request is pending, or when the current access completes this cycle.
- sram_addr  out  18  SRAM 16-bit word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data read from SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out (1 = drive).
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - LOW: accessing the low half-word.
  - HIGH: accessing the high half-word.
  - DONE: one-cycle completion state.
- A wait counter `cnt` runs 0..WAIT_CYCLES-1 inside LOW and HIGH.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - If rd_en or wr_en is high: latch op (write if wr_en, else read), latch address and write_data, clear cnt, go to LOW.
- Simultaneous rd_en and wr_en: treated as a write; read_data is not updated.
- Address map:
  - off = latched address − DATA_MEM_BASE.
  - sram_addr = {off[18:2], half}, where half = 0 in LOW and 1 in HIGH.
  - Address bits 1:0 and bits above 18 are ignored.
- LOW and HIGH:
  - cnt increments each cycle.
  - At cnt == WAIT_CYCLES-1: clear cnt and advance LOW→HIGH, or HIGH→DONE.
- Write op:
  - sram_dq_oe = 1.
  - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - sram_we_n = 0 for cnt < WAIT_CYCLES-1 and 1 on the last cycle of each phase, giving a rising edge with stable address and data.
- Read op:
  - sram_dq_oe = 0, sram_we_n = 1.
  - sram_dq_in is sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
- DONE: ready = 1 for exactly one cycle; next state IDLE unconditionally. The pipeline advances on this edge.
- Latency: with the request first seen in IDLE at cycle 0, ready is high in cycle 2·WAIT_CYCLES+1 (cycle 7 for the default). freeze is high in cycles 0..2·WAIT_CYCLES.
- Back-to-back requests: one IDLE cycle always separates accesses. A request present in that IDLE cycle starts immediately.
- Outside active phases: sram_we_n = 1, sram_dq_oe = 0, sram_addr and sram_dq_out hold their last values.
- read_data holds its value until the next read completes; writes never alter it.
- Reset (any state, including mid-access): state=IDLE, cnt=0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0. After reset, ready follows the IDLE rule.
- No combinational path from sram_dq_in to any output.

Decomposition:
- Shared package `arm_defs`:
  - DATA_MEM_BASE constant.
  - sram_state_t enum {IDLE, LOW, HIGH, DONE}.
  - SRAM_ADDR_W = 18, SRAM_DATA_W = 16.
- FSM and wait counter stay inline; no sub-module. The tristate buffer lives at the top-level pad, not in this block.

Test Plan (WAIT_CYCLES=3; SRAM behavioural model on the bench):
- Idle: rd_en = wr_en = 0 for 10 cycles → ready=1, sram_we_n=1, sram_dq_oe=0 throughout.
- Write:
  - Stimulus: wr_en=1, address=1028, write_data=0xDEADBEEF at cycle 0.
  - Low half: sram_addr=0x00002, dq_out=0xBEEF, we_n low in cycles 1–2 and high in cycle 3.
  - High half: sram_addr=0x00003, dq_out=0xDEAD, we_n low in cycles 4–5 and high in cycle 6.
  - ready=0 in cycles 0–6, ready=1 in cycle 7.
- Read after write: rd_en=1, address=1028 → dq_oe=0, we_n=1; read_data=0xDEADBEEF at cycle 7, with ready=1 that cycle.
- Simultaneous: rd_en = wr_en = 1, address=1032, write_data=0x12345678 → SRAM words 4/5 = 0x5678/0x1234; read_data unchanged; ready at cycle 7.
- Reset mid-read: rst=1 in cycle 4 of a read → next cycle state IDLE, read_data=0, we_n=1, dq_oe=0. A held rd_en then starts a fresh 8-cycle access.
- Back-to-back: two reads (1024, then 1028) presented on consecutive accepted slots → second access begins in the IDLE cycle after DONE; ready pulses at cycles 7 and 15.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared definitions for the ARM pipeline data-memory path.
// Holds the data memory base, SRAM widths and the SRAM controller state type.
package arm_defs;

  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;
  localparam int          SRAM_ADDR_W   = 18;
  localparam int          SRAM_DATA_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_controller.sv
// Splits a 32-bit MEM-stage load/store into two timed 16-bit accesses
// on an asynchronous SRAM; ready releases the pipeline freeze.
module sram_controller #(
  parameter int          WAIT_CYCLES   = 3,
  parameter logic [31:0] DATA_MEM_BASE = arm_defs::DATA_MEM_BASE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_en,
  input  logic                             wr_en,
  input  logic [31:0]                      address,
  input  logic [31:0]                      write_data,
  output logic [31:0]                      read_data,
  output logic                             ready,
  output logic [arm_defs::SRAM_ADDR_W-1:0] sram_addr,
  output logic [arm_defs::SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [arm_defs::SRAM_DATA_W-1:0] sram_dq_in,
  output logic                             sram_dq_oe,
  output logic                             sram_we_n
);
  import arm_defs::*;

  localparam int               CNT_W     = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [16:0]      BASE_WORD = DATA_MEM_BASE[18:2];

  sram_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic        op_write_reg, op_write_next;
  logic [16:0] word_off_reg, word_off_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] read_data_reg, read_data_next;
  logic [SRAM_ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic [SRAM_DATA_W-1:0] sram_dq_out_reg, sram_dq_out_next;
  logic        sram_we_n_reg, sram_we_n_next;
  logic        sram_dq_oe_reg, sram_dq_oe_next;

  // Byte-lane and upper address bits carry no information for the word map.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  // State register, latched request and registered pad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      op_write_reg    <= 1'b0;
      word_off_reg    <= '0;
      wdata_reg       <= '0;
      read_data_reg   <= '0;
      sram_addr_reg   <= '0;
      sram_dq_out_reg <= '0;
      sram_we_n_reg   <= 1'b1;
      sram_dq_oe_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      op_write_reg    <= op_write_next;
      word_off_reg    <= word_off_next;
      wdata_reg       <= wdata_next;
      read_data_reg   <= read_data_next;
      sram_addr_reg   <= sram_addr_next;
      sram_dq_out_reg <= sram_dq_out_next;
      sram_we_n_reg   <= sram_we_n_next;
      sram_dq_oe_reg  <= sram_dq_oe_next;
    end
  end

  // Next-state logic, wait counter and request capture.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_write_next = op_write_reg;
    word_off_next = word_off_reg;
    wdata_next    = wdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (rd_en || wr_en) begin
          op_write_next = wr_en;
          // Base is word aligned, so the word offset needs no borrow from bits 1:0.
          word_off_next = address[18:2] - BASE_WORD;
          wdata_next    = write_data;
          cnt_next      = '0;
          state_next    = LOW;
        end
      end
      LOW, HIGH: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = (state_reg == LOW) ? HIGH : DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: pad signals are computed for the coming cycle and registered,
  // so sram_dq_in never reaches an output combinationally.
  always_comb begin
    ready            = 1'b0;
    read_data_next   = read_data_reg;
    sram_addr_next   = sram_addr_reg;
    sram_dq_out_next = sram_dq_out_reg;
    sram_we_n_next   = 1'b1;
    sram_dq_oe_next  = 1'b0;

    unique case (state_reg)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase

    if (!op_write_reg && cnt_reg == CNT_LAST) begin
      if (state_reg == LOW)  read_data_next[15:0]  = sram_dq_in;
      if (state_reg == HIGH) read_data_next[31:16] = sram_dq_in;
    end

    if (state_next == LOW || state_next == HIGH) begin
      sram_addr_next = {word_off_next, state_next == HIGH};
      if (op_write_next) begin
        sram_dq_out_next = (state_next == HIGH) ? wdata_next[31:16] : wdata_next[15:0];
        sram_dq_oe_next  = 1'b1;
        // Strobe releases on the last cycle so the rising edge sees stable address/data.
        sram_we_n_next   = (cnt_next == CNT_LAST);
      end
    end
  end

  assign read_data   = read_data_reg;
  assign sram_addr   = sram_addr_reg;
  assign sram_dq_out = sram_dq_out_reg;
  assign sram_we_n   = sram_we_n_reg;
  assign sram_dq_oe  = sram_dq_oe_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:262143];

  sram_controller #(.WAIT_CYCLES(3), .DATA_MEM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: writes commit on the rising edge of we_n.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge sram_we_n) if (sram_dq_oe === 1'b1) mem[sram_addr] = sram_dq_out;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL rst_read_data got %h want %h", read_data, 32'h0); end
    vectors++; if (sram_addr !== 18'h0) begin miscompares++; $display("FAIL rst_sram_addr got %h want %h", sram_addr, 18'h0); end
    vectors++; if (sram_dq_out !== 16'h0) begin miscompares++; $display("FAIL rst_dq_out got %h want %h", sram_dq_out, 16'h0); end
    vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rst_we_n got %b want 1", sram_we_n); end
    vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rst_dq_oe got %b want 0", sram_dq_oe); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", ready); end
    $display("reset: released");
    next_cycle();
  endtask

  task automatic test_idle;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready c=%0d got %b want 1", c, ready); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL idle_we_n c=%0d got %b want 1", c, sram_we_n); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL idle_dq_oe c=%0d got %b want 0", c, sram_dq_oe); end
      next_cycle();
    end
    $display("idle: 10 cycles");
  endtask

  task automatic test_write;
    logic exp_we_n;
    logic exp_oe;
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_oe   = (c >= 1 && c <= 6);
      exp_we_n = !(c == 1 || c == 2 || c == 4 || c == 5);
      vectors++; if (ready !== (c == 7)) begin miscompares++; $display("FAIL wr_ready c=%0d got %b want %b", c, ready, c == 7); end
      vectors++; if (sram_we_n !== exp_we_n) begin miscompares++; $display("FAIL wr_we_n c=%0d got %b want %b", c, sram_we_n, exp_we_n); end
      vectors++; if (sram_dq_oe !== exp_oe) begin miscompares++; $display("FAIL wr_dq_oe c=%0d got %b want %b", c, sram_dq_oe, exp_oe); end
      if (c >= 1 && c <= 3) begin
        vectors++; if (sram_addr !== 18'h00002) begin miscompares++; $display("FAIL wr_addr_lo c=%0d got %h want %h", c, sram_addr, 18'h00002); end
        vectors++; if (sram_dq_out !== 16'hBEEF) begin miscompares++; $display("FAIL wr_dq_lo c=%0d got %h want %h", c, sram_dq_out, 16'hBEEF); end
      end
      if (c >= 4 && c <= 6) begin
        vectors++; if (sram_addr !== 18'h00003) begin miscompares++; $display("FAIL wr_addr_hi c=%0d got %h want %h", c, sram_addr, 18'h00003); end
        vectors++; if (sram_dq_out !== 16'hDEAD) begin miscompares++; $display("FAIL wr_dq_hi c=%0d got %h want %h", c, sram_dq_out, 16'hDEAD); end
      end
      next_cycle();
    end
    wr_en = 1'b0;
    vectors++; if (mem[2] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_mem2 got %h want %h", mem[2], 16'hBEEF); end
    vectors++; if (mem[3] !== 16'hDEAD) begin miscompares++; $display("FAIL wr_mem3 got %h want %h", mem[3], 16'hDEAD); end
    $display("write: addr=1028 data=deadbeef");
  endtask

  task automatic test_read;
    rd_en = 1'b1; address = 32'd1028;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++; if (ready !== (c == 7)) begin miscompares++; $display("FAIL rd_ready c=%0d got %b want %b", c, ready, c == 7); end
      vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rd_we_n c=%0d got %b want 1", c, sram_we_n); end
      vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rd_dq_oe c=%0d got %b want 0", c, sram_dq_oe); end
      if (c == 7) begin
        vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want %h", read_data, 32'hDEADBEEF); end
      end
      next_cycle();
    end
    rd_en = 1'b0;
    $display("read: addr=1028 data=%h", read_data);
  endtask

  task automatic test_simultaneous;
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++; if (ready !== (c == 7)) begin miscompares++; $display("FAIL sim_ready c=%0d got %b want %b", c, ready, c == 7); end
      next_cycle();
    end
    rd_en = 1'b0; wr_en = 1'b0;
    vectors++; if (mem[4] !== 16'h5678) begin miscompares++; $display("FAIL sim_mem4 got %h want %h", mem[4], 16'h5678); end
    vectors++; if (mem[5] !== 16'h1234) begin miscompares++; $display("FAIL sim_mem5 got %h want %h", mem[5], 16'h1234); end
    vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sim_read_data got %h want %h", read_data, 32'hDEADBEEF); end
    $display("simultaneous: addr=1032 data=12345678");
  endtask

  task automatic test_reset_mid_read;
    rd_en = 1'b1; address = 32'd1028;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rmr_ready_pre c=%0d got %b want 0", c, ready); end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL rmr_read_data got %h want %h", read_data, 32'h0); end
        vectors++; if (sram_we_n !== 1'b1) begin miscompares++; $display("FAIL rmr_we_n got %b want 1", sram_we_n); end
        vectors++; if (sram_dq_oe !== 1'b0) begin miscompares++; $display("FAIL rmr_dq_oe got %b want 0", sram_dq_oe); end
      end
      vectors++; if (ready !== (c == 7)) begin miscompares++; $display("FAIL rmr_ready c=%0d got %b want %b", c, ready, c == 7); end
      if (c == 7) begin
        vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rmr_final got %h want %h", read_data, 32'hDEADBEEF); end
      end
      next_cycle();
    end
    rd_en = 1'b0;
    $display("reset mid-read: restarted read addr=1028");
  endtask

  task automatic test_back_to_back;
    rd_en = 1'b1; address = 32'd1024;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vectors++; if (ready !== (c == 7 || c == 15)) begin miscompares++; $display("FAIL b2b_ready c=%0d got %b want %b", c, ready, (c == 7 || c == 15)); end
      if (c == 7) begin
        vectors++; if (read_data !== 32'h22221111) begin miscompares++; $display("FAIL b2b_first got %h want %h", read_data, 32'h22221111); end
      end
      if (c == 9) begin
        vectors++; if (sram_addr !== 18'h00002) begin miscompares++; $display("FAIL b2b_addr2 got %h want %h", sram_addr, 18'h00002); end
      end
      if (c == 15) begin
        vectors++; if (read_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL b2b_second got %h want %h", read_data, 32'hDEADBEEF); end
      end
      next_cycle();
      if (c == 7) address = 32'd1028;
    end
    rd_en = 1'b0;
    $display("back-to-back: reads 1024, 1028");
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
